// File: rtl/mem_pkg.sv
// Shared constants and types for the RV32IM data-memory responder.
package mem_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 4;

  // Legal LATENCY range; the counter holds LATENCY-1 in CNT_W bits.
  localparam int unsigned LATENCY_MIN = 1;
  localparam int unsigned LATENCY_MAX = (1 << CNT_W) - 1;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Request captured from the EX/MA register when it is accepted.
  typedef struct packed {
    logic            rd;
    logic            wr;
    logic [2:0]      func3;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/load_store_align.sv
// Byte-lane steering: func3 + low address bits -> byte enables, replicated
// store data, extended load value and misalignment/illegal-func3 flag.
module load_store_align
  import mem_pkg::*;
(
  input  logic [2:0]      func3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] write_data,
  input  logic [XLEN-1:0] stored_word,
  output logic [3:0]      byte_en,
  output logic [XLEN-1:0] store_data,
  output logic [XLEN-1:0] load_data,
  output logic            error
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Little-endian lane selection for sub-word loads
  always_comb begin
    byte_sel = stored_word[7:0];
    case (addr_lo)
      2'd0: byte_sel = stored_word[7:0];
      2'd1: byte_sel = stored_word[15:8];
      2'd2: byte_sel = stored_word[23:16];
      2'd3: byte_sel = stored_word[31:24];
      default: byte_sel = stored_word[7:0];
    endcase
    half_sel = addr_lo[1] ? stored_word[31:16] : stored_word[15:0];
  end

  // An erroring access gets no byte enables and a zero load value
  always_comb begin
    byte_en    = 4'b0000;
    store_data = '0;
    load_data  = '0;
    error      = 1'b0;
    case (func3)
      F3_B, F3_BU: begin
        byte_en    = 4'b0001 << addr_lo;
        store_data = {4{write_data[7:0]}};
        load_data  = (func3 == F3_B) ? {{24{byte_sel[7]}}, byte_sel}
                                     : {24'd0, byte_sel};
      end
      F3_H, F3_HU: begin
        if (addr_lo[0]) begin
          error = 1'b1;
        end else begin
          byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
          store_data = {2{write_data[15:0]}};
          load_data  = (func3 == F3_H) ? {{16{half_sel[15]}}, half_sel}
                                       : {16'd0, half_sel};
        end
      end
      F3_W: begin
        if (addr_lo != 2'b00) begin
          error = 1'b1;
        end else begin
          byte_en    = 4'b1111;
          store_data = write_data;
          load_data  = stored_word;
        end
      end
      default: error = 1'b1;
    endcase
  end

endmodule

// File: rtl/data_memory.sv
// Multi-cycle data memory for the MA stage: latches one load/store, waits
// LATENCY cycles with busy_wait high, then performs the access in one edge.
module data_memory
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LATENCY    = 4
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [XLEN-1:0] address,
  input  logic [XLEN-1:0] write_data,
  input  logic [2:0]      func3,
  output logic [XLEN-1:0] read_data,
  output logic            busy_wait,
  output logic            access_error
);

  localparam int unsigned WORD_AW = ADDR_WIDTH - 2;
  localparam int unsigned WORDS   = 1 << WORD_AW;

  if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_latency_check
    $error("data_memory: LATENCY must be within 1..15");
  end

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  mem_req_t           req_q;
  logic               req_c;
  logic               access_c;
  logic [WORD_AW-1:0] word_idx;
  logic [XLEN-1:0]    mem_word;
  logic [3:0]         byte_en;
  logic [XLEN-1:0]    store_data;
  logic [XLEN-1:0]    load_data;
  logic               align_err;
  logic               unused_addr_bits;

  logic [XLEN-1:0] mem [WORDS];

  assign req_c    = mem_read | mem_write;
  assign access_c = (state_q == BUSY) && (cnt_q == '0);
  assign word_idx = req_q.addr[ADDR_WIDTH-1:2];
  assign mem_word = mem[word_idx];

  // Upper address bits wrap and are deliberately ignored
  assign unused_addr_bits = ^req_q.addr[XLEN-1:ADDR_WIDTH];

  // Stall is combinational so the pipeline freezes in the request cycle
  assign busy_wait = !RESET &&
                     (((state_q == IDLE) && req_c) || (state_q == BUSY));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_c) begin
          state_d = BUSY;
          cnt_d   = CNT_W'(LATENCY - 1);
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request is sampled only in IDLE; later cycles use the latched copy
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      req_q <= '0;
    end else if ((state_q == IDLE) && req_c) begin
      req_q.rd    <= mem_read;
      req_q.wr    <= mem_write;
      req_q.func3 <= func3;
      req_q.addr  <= address;
      req_q.wdata <= write_data;
    end
  end

  load_store_align u_align (
    .func3      (req_q.func3),
    .addr_lo    (req_q.addr[1:0]),
    .write_data (req_q.wdata),
    .stored_word(mem_word),
    .byte_en    (byte_en),
    .store_data (store_data),
    .load_data  (load_data),
    .error      (align_err)
  );

  // Array has no reset; a reset before the access edge cancels the store
  always_ff @(posedge CLK) begin
    if (access_c && req_q.wr) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          mem[word_idx][8*b +: 8] <= store_data[8*b +: 8];
        end
      end
    end
  end

  // Results land on the edge entering DONE; error is a one-cycle pulse
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      read_data    <= '0;
      access_error <= 1'b0;
    end else begin
      access_error <= access_c && align_err;
      if (access_c) begin
        if (align_err || (req_q.rd && req_q.wr)) begin
          read_data <= '0;
        end else if (req_q.rd) begin
          read_data <= load_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: byte-array reference model, directed
// scenarios followed by randomized loads/stores.
module tb_data_memory;

  localparam int unsigned AW  = 10;
  localparam int unsigned LAT = 4;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        mem_read, mem_write;
  logic [31:0] address, write_data;
  logic [2:0]  func3;
  logic [31:0] read_data;
  logic        busy_wait, access_error;

  always #5 CLK = ~CLK;

  data_memory #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .address     (address),
    .write_data  (write_data),
    .func3       (func3),
    .read_data   (read_data),
    .busy_wait   (busy_wait),
    .access_error(access_error)
  );

  typedef struct {
    logic [31:0] rd;
    logic        err;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic [7:0]  model_mem [1024];
  logic [31:0] model_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Reference: byte-addressed array, access size from func3, RISC-V rules
  task automatic model_access(input bit rd, input bit wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [2:0] f3,
                              output logic [31:0] exp_rd, output logic exp_err);
    int unsigned a;
    int unsigned size;
    bit          illegal;
    logic [31:0] v;
    a       = addr % 1024;
    illegal = 1'b0;
    size    = 1;
    case (f3)
      3'b000, 3'b100: size = 1;
      3'b001, 3'b101: size = 2;
      3'b010:         size = 4;
      default:        illegal = 1'b1;
    endcase
    exp_err = illegal || ((a % size) != 0);
    if (wr && !exp_err)
      for (int i = 0; i < int'(size); i++) model_mem[a + i] = wdata[8*i +: 8];
    if (exp_err || (rd && wr)) begin
      model_rd = 32'd0;
    end else if (rd) begin
      v = 32'd0;
      for (int i = 0; i < int'(size); i++) v[8*i +: 8] = model_mem[a + i];
      if (f3 == 3'b000) v = {{24{v[7]}}, v[7:0]};
      if (f3 == 3'b001) v = {{16{v[15]}}, v[15:0]};
      model_rd = v;
    end
    exp_rd = model_rd;
  endtask

  task automatic push_expect(input string name, input bit rd, input bit wr,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [2:0] f3);
    exp_t e;
    model_access(rd, wr, addr, wdata, f3, e.rd, e.err);
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input string name);
    bit seen, done;
    seen = 1'b0;
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge CLK);
      if (busy_wait) seen = 1'b1;
      else if (seen) done = 1'b1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL timeout %s: got no completion expected one within 40 cycles", name);
    end
    @(posedge CLK);
    #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  // Called at posedge+1 in an IDLE cycle; returns at posedge+1 after DONE
  task automatic do_req(input string name, input bit rd, input bit wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] f3);
    push_expect(name, rd, wr, addr, wdata, f3);
    mem_read   = rd;
    mem_write  = wr;
    address    = addr;
    write_data = wdata;
    func3      = f3;
    wait_done(name);
  endtask

  // Monitor: a falling busy_wait marks DONE; compare against the queue head
  int busy_cnt  = 0;
  bit post_done = 1'b0;
  always @(negedge CLK) begin
    exp_t e;
    if (RESET) begin
      busy_cnt  = 0;
      post_done = 1'b0;
    end else begin
      if (post_done) begin
        check("err_pulse_end", {31'd0, access_error}, 32'd0);
        post_done = 1'b0;
      end
      if (busy_wait) begin
        busy_cnt++;
      end else if (busy_cnt > 0) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got a completion expected none");
        end else begin
          e = exp_q.pop_front();
          check({e.name, "_rdata"}, read_data, e.rd);
          check({e.name, "_err"}, {31'd0, access_error}, {31'd0, e.err});
          check({e.name, "_busy_cycles"}, 32'(busy_cnt), 32'(LAT + 1));
        end
        busy_cnt  = 0;
        post_done = 1'b1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish before 200us");
    $fatal(1);
  end

  initial begin
    logic [2:0]  legal_f3 [5];
    logic [2:0]  f3;
    logic [31:0] addr;
    int unsigned kind;

    for (int i = 0; i < 1024; i++) model_mem[i] = 8'd0;
    model_rd   = 32'd0;
    legal_f3   = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    RESET      = 1'b1;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    address    = 32'd0;
    write_data = 32'd0;
    func3      = 3'b010;

    repeat (2) @(negedge CLK);
    check("reset_read_data", read_data, 32'd0);
    check("reset_busy", {31'd0, busy_wait}, 32'd0);
    check("reset_err", {31'd0, access_error}, 32'd0);
    @(posedge CLK);
    #1 RESET = 1'b0;
    @(posedge CLK);
    #1;

    do_req("sw_10",      1'b0, 1'b1, 32'h010, 32'hDEADBEEF, 3'b010);
    do_req("lw_10",      1'b1, 1'b0, 32'h010, 32'h0,        3'b010);
    do_req("sb_11",      1'b0, 1'b1, 32'h011, 32'hAB12C07F, 3'b000);
    do_req("lw_10_b",    1'b1, 1'b0, 32'h010, 32'h0,        3'b010);
    do_req("lb_13",      1'b1, 1'b0, 32'h013, 32'h0,        3'b000);
    do_req("lbu_13",     1'b1, 1'b0, 32'h013, 32'h0,        3'b100);
    do_req("lh_12",      1'b1, 1'b0, 32'h012, 32'h0,        3'b001);
    do_req("lhu_12",     1'b1, 1'b0, 32'h012, 32'h0,        3'b101);
    do_req("sw_12_mis",  1'b0, 1'b1, 32'h012, 32'h11111111, 3'b010);
    do_req("lw_10_c",    1'b1, 1'b0, 32'h010, 32'h0,        3'b010);
    do_req("sw_404",     1'b0, 1'b1, 32'h404, 32'h12345678, 3'b010);
    do_req("lw_004",     1'b1, 1'b0, 32'h004, 32'h0,        3'b010);
    do_req("rw_both",    1'b1, 1'b1, 32'h018, 32'hCAFEF00D, 3'b010);
    do_req("lw_illegal", 1'b1, 1'b0, 32'h018, 32'h0,        3'b011);
    do_req("lw_004_b",   1'b1, 1'b0, 32'h004, 32'h0,        3'b010);

    // Reset in the second BUSY cycle of a store; a load is then held across it
    mem_read   = 1'b0;
    mem_write  = 1'b1;
    address    = 32'h020;
    write_data = 32'hFFFFFFFF;
    func3      = 3'b010;
    @(posedge CLK);
    @(posedge CLK);
    #2;
    RESET     = 1'b1;
    mem_write = 1'b0;
    mem_read  = 1'b1;
    model_rd  = 32'd0;
    #1;
    check("midreset_read_data", read_data, 32'd0);
    check("midreset_busy", {31'd0, busy_wait}, 32'd0);
    check("midreset_err", {31'd0, access_error}, 32'd0);
    push_expect("lw_20_after_reset", 1'b1, 1'b0, 32'h020, 32'h0, 3'b010);
    @(posedge CLK);
    #1 RESET = 1'b0;
    wait_done("lw_20_after_reset");

    for (int n = 0; n < 200; n++) begin
      kind = $urandom_range(0, 9);
      if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
      else f3 = legal_f3[$urandom_range(0, 4)];
      addr = 32'h100 + 32'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) addr = addr | ($urandom & 32'hFFFFFC00);
      do_req($sformatf("rand%0d", n), (kind < 4) || (kind >= 8),
             (kind >= 4) && (kind <= 8), addr, $urandom, f3);
    end

    repeat (3) @(negedge CLK);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
